processing_writeback: RTL
=========================

PROCESSING_WRITEBACK -- requirements
Module: processing_writeback

Interface
REQ-001 Parameter CORES, default 32, SHALL set the number of ALU lanes.
REQ-002 Parameter BITS, default 16, SHALL set the bits per lane (bf16).
REQ-003 Parameter ADDR_WIDTH, default 8, SHALL set the register-file address width.
REQ-004 Parameter ALU_LAT, default 2, range 1..8, SHALL set the cycles from issue to a valid alu_out.
REQ-005 Parameter DEPTH, default 4, power of two, SHALL set the number of result-queue entries.
REQ-006 Port clock, input, 1 bit, SHALL be the single clock; all state SHALL update on its rising edge.
REQ-007 Port reset_n, input, 1 bit, SHALL be the asynchronous, active-low reset.
REQ-008 Port issue_valid, input, 1 bit, SHALL flag an ALU op issued this cycle that needs writeback.
REQ-009 Port issue_ready, output, 1 bit, SHALL indicate the block can accept an issue.
REQ-010 Port issue_dest, input, ADDR_WIDTH bits, SHALL carry the destination register of the issued op.
REQ-011 Port alu_out, input, CORES*BITS bits, SHALL carry the concatenated lane results; lane i is at [i*BITS +: BITS].
REQ-012 Port ext_write, input, 1 bit, SHALL signal an external write that owns the register-file write port this cycle.
REQ-013 Port wb_write, output, 1 bit, SHALL be the register-file write enable.
REQ-014 Port wb_addr, output, ADDR_WIDTH bits, SHALL be the register-file write address.
REQ-015 Port wb_data, output, CORES*BITS bits, SHALL be the register-file write data.
REQ-016 Port busy, output, 1 bit, SHALL be high while any op is in flight or queued.
REQ-017 Port overflow, output, 1 bit, SHALL be a sticky error flag.

Function
REQ-018 An issue SHALL be accepted when issue_valid and issue_ready are both high at a rising clock edge.
REQ-019 The block SHALL hold an ALU_LAT-stage tag pipeline of {valid, dest}; an issue accepted at edge t SHALL enter stage 0 and shift one stage per cycle.
REQ-020 When the last tag stage is valid, alu_out SHALL be captured with that dest into the queue tail on that edge, i.e. the edge ALU_LAT cycles after acceptance.
REQ-021 inflight SHALL equal the count of valid tag stages; count SHALL equal the queue occupancy (0..DEPTH).
REQ-022 issue_ready SHALL be (count + inflight) < DEPTH, computed from registered state only, with no path from issue_valid or ext_write.
REQ-023 wb_write SHALL be (count != 0) && !ext_write; wb_addr and wb_data SHALL be the queue head, combinationally.
REQ-024 The head SHALL be popped on each edge where wb_write is high.
REQ-025 Minimum latency SHALL be: write visible ALU_LAT+1 cycles after acceptance with no ext_write.
REQ-026 Writes SHALL be in issue order; same-dest ops SHALL each produce a write in order, with no merging.
REQ-027 A simultaneous push and pop SHALL leave count unchanged and keep both entries intact.
REQ-028 Queue pointers SHALL wrap modulo DEPTH.
REQ-029 ext_write high SHALL stall the drain only; tag shifting and capture SHALL continue.
REQ-030 A capture while count == DEPTH with no pop SHALL drop the result and set overflow, which SHALL stay high until reset; REQ-022 makes this unreachable in correct use.
REQ-031 busy SHALL be (inflight != 0) || (count != 0).
REQ-032 When wb_write is low, wb_addr and wb_data SHALL be don't-care.

Reset
REQ-033 Asserting reset_n low SHALL immediately clear all tag valids, count, the pointers and overflow, regardless of clock.
REQ-034 During reset, outputs SHALL be wb_write=0, issue_ready=1, busy=0, overflow=0.
REQ-035 Reset mid-operation SHALL discard in-flight and queued results; no write for a pre-reset issue SHALL occur after release.
REQ-036 Queue data storage SHALL NOT require reset.

Verification (ALU_LAT=2, DEPTH=4)
REQ-037 Single op: issue dest=0x05 at cycle 0, alu_out=32x0x3F80 at cycle 2 -> wb_write=1, wb_addr=0x05, wb_data=32x0x3F80 in cycle 3 only; busy=0 from cycle 4.
REQ-038 Back-pressure: ext_write=1, issue dests 0x01..0x04 in cycles 0..3 -> issue_ready=0 from cycle 4; no wb_write; drop ext_write at cycle 8 -> writes 0x01,0x02,0x03,0x04 in cycles 8..11; issue_ready=1 in cycle 9.
REQ-039 Stall pulse: two queued results (0x10, 0x11), ext_write=1 for one cycle during drain -> wb_write low that cycle; exactly one write each of 0x10 then 0x11, no loss or duplicate.
REQ-040 Push/pop overlap: continuous issues every cycle, ext_write=0 -> one write per cycle from cycle 3; count stays at or below 1; overflow=0.
REQ-041 Reset mid-op: 2 in flight plus 1 queued, reset_n low mid-cycle -> wb_write=0 and busy=0 immediately; after release with alu_out still toggling, no wb_write.
REQ-042 Wrap: 10 sequential ops through DEPTH=4 with ext_write toggling every 2 cycles -> all 10 addresses written once, in order.

Source files
------------

// File: rtl/processing_writeback.sv
// Writeback stage: tracks issued ALU ops through a tag pipeline, captures their
// results into an in-order queue, and drains the queue into the register file.
module processing_writeback #(
  parameter int CORES      = 32,
  parameter int BITS       = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int ALU_LAT    = 2,
  parameter int DEPTH      = 4
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    issue_valid,
  output logic                    issue_ready,
  input  logic [ADDR_WIDTH-1:0]   issue_dest,
  input  logic [CORES*BITS-1:0]   alu_out,
  input  logic                    ext_write,
  output logic                    wb_write,
  output logic [ADDR_WIDTH-1:0]   wb_addr,
  output logic [CORES*BITS-1:0]   wb_data,
  output logic                    busy,
  output logic                    overflow
);

  localparam int DW = CORES * BITS;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(ALU_LAT + 1);
  localparam int SW = ((CW > IW) ? CW : IW) + 1;

  logic [ALU_LAT-1:0]    r_tag_vld;
  logic [ADDR_WIDTH-1:0] r_tag_dest [ALU_LAT];
  logic [ADDR_WIDTH-1:0] r_q_dest   [DEPTH];
  logic [DW-1:0]         r_q_data   [DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  r_overflow;

  logic [IW-1:0] w_inflight;
  logic          w_accept;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_store;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < ALU_LAT; i++) begin
      w_inflight = w_inflight + IW'(r_tag_vld[i]);
    end
  end

  // Readiness reserves a queue slot for every op still in the tag pipeline.
  assign issue_ready = (SW'(r_count) + SW'(w_inflight)) < SW'(DEPTH);
  assign w_accept    = issue_valid && issue_ready;
  assign w_push      = r_tag_vld[ALU_LAT-1];
  assign w_pop       = wb_write;
  assign w_full      = (r_count == CW'(DEPTH));
  assign w_store     = w_push && (!w_full || w_pop);

  assign wb_write = (r_count != '0) && !ext_write;
  assign wb_addr  = r_q_dest[r_rd_ptr];
  assign wb_data  = r_q_data[r_rd_ptr];
  assign busy     = (w_inflight != '0) || (r_count != '0);
  assign overflow = r_overflow;

  // Tag pipeline: valid bits are reset, destinations are qualified by them.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_tag_vld <= '0;
    end else begin
      r_tag_vld[0] <= w_accept;
      for (int i = 1; i < ALU_LAT; i++) begin
        r_tag_vld[i] <= r_tag_vld[i-1];
      end
    end
  end

  always_ff @(posedge clock) begin
    r_tag_dest[0] <= issue_dest;
    for (int i = 1; i < ALU_LAT; i++) begin
      r_tag_dest[i] <= r_tag_dest[i-1];
    end
  end

  always_ff @(posedge clock) begin
    if (w_store) begin
      r_q_dest[r_wr_ptr] <= r_tag_dest[ALU_LAT-1];
      r_q_data[r_wr_ptr] <= alu_out;
    end
  end

  // Queue control; a capture into a full queue with no pop is dropped.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_store) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_pop)   r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_store, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_overflow <= r_overflow || (w_push && !w_store);
    end
  end

endmodule
